// File: rtl/workload_pkg.sv
// Shared types and constants for the workload issuer and its issue buffer.
package workload_pkg;

  // Instruction width carried by a buffer entry; the workload FIFO width must match.
  localparam int INSN_W = 32;

  // Pad instruction appended after the workload: addi x0,x0,0.
  localparam logic [INSN_W-1:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic              last;
    logic [INSN_W-1:0] data;
  } insn_entry_t;

endpackage

// File: rtl/workload_skid_buf.sv
// Two-entry in-order queue between the workload FIFO and the core instruction port.
// Slot 0 is always the head; a pop shifts slot 1 down, and a push lands in the
// first free slot after any pop of the same cycle.
module workload_skid_buf
  import workload_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  insn_entry_t push_entry,
  input  logic        pop,
  output insn_entry_t head_entry,
  output logic [1:0]  occupancy
);

  insn_entry_t slot_reg  [2];
  insn_entry_t slot_next [2];
  logic [1:0]  occ_reg;
  logic [1:0]  occ_next;

  // Next-state of the queue: apply the pop first, then append the push behind it.
  always_comb begin
    slot_next[0] = slot_reg[0];
    slot_next[1] = slot_reg[1];
    occ_next     = occ_reg;
    if (pop && (occ_reg != 2'd0)) begin
      slot_next[0] = slot_reg[1];
      slot_next[1] = '0;
      occ_next     = occ_reg - 2'd1;
    end
    if (push && (occ_next < 2'd2)) begin
      slot_next[occ_next[0]] = push_entry;
      occ_next               = occ_next + 2'd1;
    end
  end

  // Queue storage and occupancy; reset clears the data so the outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg[0] <= '0;
      slot_reg[1] <= '0;
      occ_reg     <= 2'd0;
    end else begin
      slot_reg[0] <= slot_next[0];
      slot_reg[1] <= slot_next[1];
      occ_reg     <= occ_next;
    end
  end

  assign head_entry = slot_reg[0];
  assign occupancy  = occ_reg;

endmodule

// File: rtl/workload_issuer.sv
// Drains the preloaded workload FIFO into the core instruction port, then appends
// PAD_COUNT NOPs to flush the pipeline and reports completion.
module workload_issuer
  import workload_pkg::*;
#(
  parameter int                    INSN_WIDTH = 32,
  parameter int                    PAD_COUNT  = 4,
  parameter int                    CNT_WIDTH  = 16,
  parameter logic [INSN_WIDTH-1:0] NOP_INSN   = workload_pkg::NOP_INSN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  fifo_rd,
  input  logic [INSN_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [INSN_WIDTH-1:0] insn_data,
  output logic                  insn_last,
  output logic [CNT_WIDTH-1:0]  issued_cnt,
  output logic                  busy,
  output logic                  done
);

  localparam logic [7:0] PAD_LIMIT = 8'(PAD_COUNT);
  localparam logic [7:0] PAD_LAST  = 8'(PAD_COUNT - 1);

  state_t               state_reg;
  logic [7:0]           pad_cnt_reg;
  logic [CNT_WIDTH-1:0] issued_cnt_reg;

  logic        push_ok;
  logic        pad_slot;
  logic        pad_push;
  logic        push;
  logic        pop;
  logic [1:0]  occupancy;
  insn_entry_t push_entry;
  insn_entry_t head_entry;

  // Issue decisions depend only on registered state and the FIFO flag, never on insn_ready.
  assign push_ok = (occupancy < 2'd2);
  assign fifo_rd = (state_reg == RUN) && !fifo_empty && push_ok;

  // The RUN cycle that sees the FIFO empty already acts as the first pad slot, so
  // the NOPs follow the workload with no bubble.
  assign pad_slot = (state_reg == PAD) || ((state_reg == RUN) && fifo_empty);
  assign pad_push = pad_slot && push_ok && (pad_cnt_reg < PAD_LIMIT);
  assign push     = fifo_rd || pad_push;
  assign pop      = insn_valid && insn_ready;

  // Push source: a FIFO entry while reading, otherwise a pad NOP tagged if final.
  always_comb begin
    push_entry = '0;
    if (fifo_rd) begin
      push_entry.last = 1'b0;
      push_entry.data = fifo_rdata;
    end else begin
      push_entry.last = (pad_cnt_reg == PAD_LAST);
      push_entry.data = NOP_INSN;
    end
  end

  workload_skid_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .occupancy  (occupancy)
  );

  // Issue sequencing: IDLE -> RUN -> PAD -> DONE, plus the pad counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pad_cnt_reg <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: if (start) state_reg <= RUN;
        RUN:  if (fifo_empty) state_reg <= PAD;
        PAD:  if (pop && head_entry.last) state_reg <= DONE;
        DONE: state_reg <= DONE;
        default: state_reg <= IDLE;
      endcase
      if (pad_push) pad_cnt_reg <= pad_cnt_reg + 8'd1;
    end
  end

  // Count accepted handshakes, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt_reg <= '0;
    end else if (pop && (issued_cnt_reg != {CNT_WIDTH{1'b1}})) begin
      issued_cnt_reg <= issued_cnt_reg + 1'b1;
    end
  end

  assign insn_valid = (occupancy != 2'd0);
  assign insn_data  = head_entry.data;
  assign insn_last  = head_entry.last;
  assign issued_cnt = issued_cnt_reg;
  assign busy       = (state_reg == RUN) || (state_reg == PAD);
  assign done       = (state_reg == DONE);

endmodule
